pixel_compositor: RTL
=====================

# pixel_compositor

Parametrised, pipelined per-pixel compositor between the VGA timing/scan logic and the DAC outputs. Each valid pixel request carries a maze tile index, in-tile offset, item code and N sprite-layer hits. The block fetches tile colour from the external tileset ROM, layers items and sprites by fixed priority, resolves the colour index through a run-time writable palette, and emits registered 24-bit RGB. It adds palette writes, multi-sprite layering, a fixed 4-cycle latency and energizer blinking.

## Interface
Parameters:
- N_SPR, default 5: number of sprite layers (Pac-Man plus 4 ghosts).
- IDX_W, default 4: colour-index width; palette depth is 2**IDX_W.
- TILE_W, default 6: tile-index width.
- OFS_W, default 6: in-tile offset width (8x8 tile).
- BLINK_FRAMES, default 8: frames per energizer blink half-period (at least 1).

Ports:
- i_clk, in, 1: clock; all state updates on the rising edge.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_valid, in, 1: pixel request this cycle.
- i_mode, in, 2: MODE_BLANK, MODE_MAP, MODE_SOLID.
- i_tile_idx, in, TILE_W: maze tile index.
- i_tile_ofs, in, OFS_W: pixel offset inside the tile.
- i_item, in, 2: I_NONE, I_DOT, I_ENERGIZER.
- i_solid_idx, in, IDX_W: colour index used in MODE_SOLID.
- i_spr_hit, in, N_SPR: per-layer coverage.
- i_spr_idx, in, N_SPR*IDX_W: per-layer colour index; layer k occupies bits [k*IDX_W +: IDX_W].
- i_frame_start, in, 1: one-cycle pulse at the start of each frame.
- o_tile_addr, out, TILE_W+OFS_W: tileset ROM address.
- i_tile_data, in, IDX_W: ROM data, valid one cycle after the address.
- i_pal_we, in, 1: palette write strobe.
- i_pal_addr, in, IDX_W: palette write address.
- i_pal_rgb, in, 24: palette write data, ordered {R,G,B}.
- o_valid, out, 1: RGB outputs valid.
- o_VGA_R, o_VGA_G, o_VGA_B, out, 8 each: pixel colour.

## Operation
- No backpressure. Every request produces exactly one output, in order.
- Stage S1 registers the request. o_tile_addr = tile_idx*2**OFS_W + ofs, driven from the S1 registers. Width arithmetic is TILE_W+OFS_W bits, with no overflow.
- Stage S2 captures ROM data plus delayed sideband signals.
- Stage S3 selects the colour index. Priority, highest first:
  - MODE_BLANK gives index 0.
  - MODE_SOLID gives i_solid_idx.
  - MODE_MAP resolves in this order:
    - The lowest-numbered sprite k with hit=1 and a non-zero index. Index 0 is transparent, so evaluation falls through to the next layer.
    - I_DOT with DOT_MASK[ofs]=1 gives ITEM_IDX.
    - I_ENERGIZER with ENERGIZER_MASK[ofs]=1 and blink_on=1 gives ITEM_IDX.
    - Otherwise the tile data.
- Stage S4 performs the palette lookup into the output registers.
- o_valid is the request valid delayed 4 cycles. RGB outputs hold their last value while o_valid=0.
- Palette: 2**IDX_W entries of 24 bits.
  - A write commits at the clock edge.
  - A lookup of the same entry in the same cycle returns the old value.
  - Reset loads DEFAULT_PALETTE.
- Blink: a frame counter 0..BLINK_FRAMES-1 advances on each i_frame_start.
  - On wrap it returns to 0 and toggles blink_on.
  - blink_on is sampled at S3, so a frame_start concurrent with in-flight pixels affects only pixels still reaching S3 afterwards.
  - With BLINK_FRAMES=1, blink_on toggles every frame.
- Reset (asynchronous, any time, including mid-stream):
  - All stage valids cleared and o_valid=0.
  - o_VGA_R/G/B=0 and o_tile_addr=0.
  - Counter=0, blink_on=1.
  - Palette reloaded to defaults.
  - In-flight pixels are discarded, never emitted.

## Timing
- Request sampled at the end of cycle n. o_tile_addr valid in n+1. ROM samples it at the end of n+1, so i_tile_data is valid in n+2.
- Colour index registered at the end of n+2. RGB and o_valid are presented in cycle n+4. Latency is 4 cycles; throughput is 1 pixel/cycle.
- A palette write in cycle m affects outputs for pixels whose S4 lookup occurs in cycle m+1 or later.
- The external ROM must be rising-edge synchronous with exactly 1-cycle read latency.

## Configuration
- PIXEL_COMPOSITOR_BLINK_EN defined: energizer blinking as described.
- Undefined: the counter and blink_on are not built, energizers are always drawn, and i_frame_start is ignored.

## Structure
- Shared package holds:
  - MODE_* and I_* enums.
  - DOT_MASK and ENERGIZER_MASK (64-bit).
  - ITEM_IDX.
  - DEFAULT_PALETTE: index 0 black, index 1 maze blue, index 2 white, 3..7 ghost and Pac-Man colours, the rest black.
- One sub-module, palette_regfile: parametrised register array with one write port and one read port. It has asynchronous reset to the defaults and old-data-on-collision behaviour.

## Test plan
- Reset mid-stream: stream 10 pixels, assert i_rst_n low after 2 cycles, release. Required: o_valid=0 and RGB=0 during reset, and no stale pixels afterwards. The first new request appears exactly 4 cycles after sampling.
- MODE_MAP tile: tile_idx=3, ofs=10. Required: o_tile_addr=202 in n+1. ROM returns 1, so the output is the index-1 palette colour in n+4.
- Sprite priority:
  - hit=5'b00110, layer1 idx=0, layer2 idx=4. Required: index-4 colour (layer 1 is transparent).
  - Second case, layer1 idx=3. Required: index-3 colour.
- Item: I_DOT at an offset with DOT_MASK=1 gives white (ITEM_IDX). At an offset with DOT_MASK=0 the tile colour is shown.
- Blink (BLINK_FRAMES=2): energizer pixel drawn after reset. After 2 i_frame_start pulses the tile colour is shown; after 4 pulses it is drawn again.
- Palette collision:
  - Write index 2 = 24'h123456 in the same cycle S4 reads index 2. Required: old white output.
  - Next pixel: R=12h, G=34h, B=56h.

Source files
------------

// File: rtl/pixel_compositor_pkg.sv
// ============================================================================
// Module   : pixel_compositor_pkg
// Brief    : Shared types, item masks and default palette for the compositor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package pixel_compositor_pkg;

  typedef enum logic [1:0] {
    MODE_BLANK = 2'd0,
    MODE_MAP   = 2'd1,
    MODE_SOLID = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    I_NONE      = 2'd0,
    I_DOT       = 2'd1,
    I_ENERGIZER = 2'd2
  } item_e;

  // 8x8 tile, bit index = row*8 + col. Dot is a 2x2 centre block.
  localparam logic [63:0] DOT_MASK       = 64'h0000_0018_1800_0000;
  // Energizer is a rounded 6x6 disc.
  localparam logic [63:0] ENERGIZER_MASK = 64'h003C_7E7E_7E7E_3C00;

  // Items are drawn with the white palette entry.
  localparam int ITEM_IDX = 2;

  // Reset contents of the palette: black, maze blue, white, ghosts, Pac-Man.
  function automatic logic [23:0] default_palette(input int idx);
    logic [23:0] rgb;
    case (idx)
      1:       rgb = 24'h2121DE;
      2:       rgb = 24'hFFFFFF;
      3:       rgb = 24'hFF0000;
      4:       rgb = 24'hFFB8FF;
      5:       rgb = 24'h00FFFF;
      6:       rgb = 24'hFFB852;
      7:       rgb = 24'hFFFF00;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_compositor_if.sv
// ============================================================================
// Module   : pixel_compositor_if
// Brief    : Pixel request, tileset ROM, palette write and RGB output bundle.
//            master = scan logic / ROM / CPU side, slave = compositor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pixel_compositor_if #(
  parameter int N_SPR  = 5,
  parameter int IDX_W  = 4,
  parameter int TILE_W = 6,
  parameter int OFS_W  = 6
) ();

  logic                      i_valid;
  logic [1:0]                i_mode;
  logic [TILE_W-1:0]         i_tile_idx;
  logic [OFS_W-1:0]          i_tile_ofs;
  logic [1:0]                i_item;
  logic [IDX_W-1:0]          i_solid_idx;
  logic [N_SPR-1:0]          i_spr_hit;
  logic [N_SPR*IDX_W-1:0]    i_spr_idx;
  logic                      i_frame_start;
  logic [TILE_W+OFS_W-1:0]   o_tile_addr;
  logic [IDX_W-1:0]          i_tile_data;
  logic                      i_pal_we;
  logic [IDX_W-1:0]          i_pal_addr;
  logic [23:0]               i_pal_rgb;
  logic                      o_valid;
  logic [7:0]                o_VGA_R;
  logic [7:0]                o_VGA_G;
  logic [7:0]                o_VGA_B;

  modport master (
    output i_valid, i_mode, i_tile_idx, i_tile_ofs, i_item, i_solid_idx,
           i_spr_hit, i_spr_idx, i_frame_start, i_tile_data,
           i_pal_we, i_pal_addr, i_pal_rgb,
    input  o_tile_addr, o_valid, o_VGA_R, o_VGA_G, o_VGA_B
  );

  modport slave (
    input  i_valid, i_mode, i_tile_idx, i_tile_ofs, i_item, i_solid_idx,
           i_spr_hit, i_spr_idx, i_frame_start, i_tile_data,
           i_pal_we, i_pal_addr, i_pal_rgb,
    output o_tile_addr, o_valid, o_VGA_R, o_VGA_G, o_VGA_B
  );

endinterface

`default_nettype wire

// File: rtl/pixel_compositor_palette_regfile.sv
// ============================================================================
// Module   : palette_regfile
// Brief    : 2**ADDR_W x 24-bit palette, one write port, one combinational
//            read port. A read of the entry being written returns old data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module palette_regfile
  import pixel_compositor_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [23:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [23:0]       rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [23:0] mem [DEPTH];

  // Storage: reload defaults on reset, otherwise commit writes at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= default_palette(i);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge contents, giving old data on collision.
  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/pixel_compositor.sv
// ============================================================================
// Module   : pixel_compositor
// Brief    : 4-stage per-pixel compositor: tile fetch, item/sprite layering,
//            palette lookup, registered 24-bit RGB.
//            Optional macro PIXEL_COMPOSITOR_BLINK_EN enables energizer blink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pixel_compositor
  import pixel_compositor_pkg::*;
#(
  parameter int N_SPR        = 5,
  parameter int IDX_W        = 4,
  parameter int TILE_W       = 6,
  parameter int OFS_W        = 6,
  parameter int BLINK_FRAMES = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  pixel_compositor_if.slave  bus
);

  logic                   v1, v2, v3, v4;
  logic [1:0]             mode1, mode2;
  logic [TILE_W-1:0]      tile1;
  logic [OFS_W-1:0]       ofs1, ofs2;
  logic [1:0]             item1, item2;
  logic [IDX_W-1:0]       solid1, solid2;
  logic [N_SPR-1:0]       hit1, hit2;
  logic [N_SPR*IDX_W-1:0] sidx1, sidx2;
  logic [IDX_W-1:0]       idx_sel, idx3;
  logic                   blink_on;
  logic [23:0]            pal_rgb;
  logic [23:0]            rgb4;

  // S1: register the incoming request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1 <= 1'b0; mode1 <= '0; tile1 <= '0; ofs1 <= '0; item1 <= '0;
      solid1 <= '0; hit1 <= '0; sidx1 <= '0;
    end else begin
      v1 <= bus.i_valid;      mode1 <= bus.i_mode;
      tile1 <= bus.i_tile_idx; ofs1 <= bus.i_tile_ofs;
      item1 <= bus.i_item;    solid1 <= bus.i_solid_idx;
      hit1 <= bus.i_spr_hit;  sidx1 <= bus.i_spr_idx;
    end
  end

  // Concatenation is exactly tile*2**OFS_W + ofs.
  assign bus.o_tile_addr = {tile1, ofs1};

  // S2: delay the sideband to line up with the ROM data arriving next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2 <= 1'b0; mode2 <= '0; ofs2 <= '0; item2 <= '0;
      solid2 <= '0; hit2 <= '0; sidx2 <= '0;
    end else begin
      v2 <= v1; mode2 <= mode1; ofs2 <= ofs1; item2 <= item1;
      solid2 <= solid1; hit2 <= hit1; sidx2 <= sidx1;
    end
  end

`ifdef PIXEL_COMPOSITOR_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CNT_W-1:0] frame_cnt;

  // Frame counter: toggle blink phase each time the count wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (bus.i_frame_start) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_frame_start;
  assign unused_frame_start = bus.i_frame_start;
  assign blink_on = 1'b1;
`endif

  // S3 select: mode, then first opaque sprite, then items, then tile data.
  always_comb begin
    logic found;
    idx_sel = bus.i_tile_data;
    found   = 1'b0;
    case (mode2)
      MODE_SOLID: idx_sel = solid2;
      MODE_MAP: begin
        for (int k = 0; k < N_SPR; k++) begin
          if (!found && hit2[k] && (sidx2[k*IDX_W +: IDX_W] != '0)) begin
            idx_sel = sidx2[k*IDX_W +: IDX_W];
            found   = 1'b1;
          end
        end
        if (!found) begin
          if (item2 == I_DOT && DOT_MASK[ofs2]) begin
            idx_sel = IDX_W'(ITEM_IDX);
          end else if (item2 == I_ENERGIZER && ENERGIZER_MASK[ofs2] && blink_on) begin
            idx_sel = IDX_W'(ITEM_IDX);
          end
        end
      end
      default: idx_sel = '0;
    endcase
  end

  // S3 register: colour index and valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v3   <= 1'b0;
      idx3 <= '0;
    end else begin
      v3   <= v2;
      idx3 <= idx_sel;
    end
  end

  palette_regfile #(.ADDR_W(IDX_W)) u_palette (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (bus.i_pal_we),
    .waddr (bus.i_pal_addr),
    .wdata (bus.i_pal_rgb),
    .raddr (idx3),
    .rdata (pal_rgb)
  );

  // S4: register the looked-up colour; hold it while no pixel is valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v4   <= 1'b0;
      rgb4 <= '0;
    end else begin
      v4 <= v3;
      if (v3) rgb4 <= pal_rgb;
    end
  end

  assign bus.o_valid = v4;
  assign bus.o_VGA_R = rgb4[23:16];
  assign bus.o_VGA_G = rgb4[15:8];
  assign bus.o_VGA_B = rgb4[7:0];

endmodule

`default_nettype wire
